// File: rtl/multu_hilo_pkg.sv
// multu_hilo_pkg
//   Shared definitions for the ALU function-code stream and the iterative
//   multiplier: 6-bit function codes (common with the ALU controller) and
//   the multiplier state encoding.
package multu_hilo_pkg;

  // ALU controller function codes
  localparam logic [5:0] AND     = 6'b100100;
  localparam logic [5:0] OR      = 6'b100101;
  localparam logic [5:0] ADD     = 6'b100000;
  localparam logic [5:0] SUB     = 6'b100010;
  localparam logic [5:0] SLT     = 6'b101010;
  localparam logic [5:0] SLL     = 6'b000000;
  localparam logic [5:0] MULTU   = 6'b011001;
  localparam logic [5:0] MFHI    = 6'b010000;
  localparam logic [5:0] MFLO    = 6'b010010;
  localparam logic [5:0] HILO_WR = 6'b111111;  // "open HiLo": commit product

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multu_hilo_step.sv
// multu_hilo_step
//   One combinational shift-add multiply step.
//   Ports:
//     mcand  in  WIDTH    multiplicand
//     p_in   in  2*WIDTH  {partial sum, remaining multiplier bits}
//     p_out  out 2*WIDTH  product register after one step
module multu_hilo_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   mcand,
  input  logic [2*WIDTH-1:0] p_in,
  output logic [2*WIDTH-1:0] p_out
);

  logic [WIDTH:0] sum;

  // The W+1-bit sum keeps the carry; shifting the whole register right by
  // one drops the consumed multiplier bit and lands the carry in the MSB.
  assign sum   = {1'b0, p_in[2*WIDTH-1:WIDTH]} + (p_in[0] ? {1'b0, mcand} : '0);
  assign p_out = {sum, p_in[WIDTH-1:1]};

endmodule

// File: rtl/multu_hilo.sv
// multu_hilo
//   Iterative unsigned shift-add multiplier with HI/LO result registers,
//   driven by the ALU controller's function-code stream.
//   Ports:
//     clk      in   system clock, rising edge
//     rst      in   asynchronous active-high reset
//     Signal   in   6-bit function code (MULTU / HILO_WR / MFHI / MFLO ...)
//     dataA    in   multiplicand, sampled when a multiply starts
//     dataB    in   multiplier, sampled when a multiply starts
//     dataOut  out  HI on MFHI, LO on MFLO, otherwise 0
//     busy     out  multiplier not idle
//     done     out  one-cycle pulse after HI/LO is written
module multu_hilo
  import multu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand, mcand_next;
  logic [2*WIDTH-1:0] p, p_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [WIDTH-1:0]   hi, hi_next;
  logic [WIDTH-1:0]   lo, lo_next;
  logic               done_next;

  logic [WIDTH-1:0]   step_mcand;
  logic [2*WIDTH-1:0] step_p_in;
  logic [2*WIDTH-1:0] step_p_out;

  // The first step happens on the start edge itself, so in IDLE the step
  // is fed straight from the operand inputs rather than the registers.
  always_comb begin
    step_mcand = mcand;
    step_p_in  = p;
    if (state == IDLE) begin
      step_mcand = dataA;
      step_p_in  = {{WIDTH{1'b0}}, dataB};
    end
  end

  multu_hilo_step #(.WIDTH(WIDTH)) u_step (
    .mcand (step_mcand),
    .p_in  (step_p_in),
    .p_out (step_p_out)
  );

  always_comb begin
    state_next = state;
    mcand_next = mcand;
    p_next     = p;
    cnt_next   = cnt;
    hi_next    = hi;
    lo_next    = lo;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (Signal == MULTU) begin
          mcand_next = dataA;
          p_next     = step_p_out;
          cnt_next   = CNT_W'(1);
          state_next = RUN;
        end
      end
      RUN: begin
        if (Signal == MULTU) begin
          p_next   = step_p_out;
          cnt_next = cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state_next = DONE;
          end
        end else begin
          // Any other code (HILO_WR included) abandons the multiply.
          state_next = IDLE;
        end
      end
      DONE: begin
        if (Signal == HILO_WR) begin
          hi_next    = p[2*WIDTH-1:WIDTH];
          lo_next    = p[WIDTH-1:0];
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (Signal != MULTU) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      p     <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      mcand <= mcand_next;
      p     <= p_next;
      cnt   <= cnt_next;
      hi    <= hi_next;
      lo    <= lo_next;
      done  <= done_next;
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    dataOut = '0;
    case (Signal)
      MFHI:    dataOut = hi;
      MFLO:    dataOut = lo;
      default: dataOut = '0;
    endcase
  end

endmodule

// File: tb/tb_multu_hilo.sv
// tb_multu_hilo
//   Randomized self-checking bench for multu_hilo. Commits push the
//   arithmetic product into a scoreboard queue; a monitor pops it when
//   done pulses and checks the MFHI/MFLO readback that follows.
module tb_multu_hilo;
  import multu_hilo_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    sig = ADD;
  logic [W-1:0]  data_a = '0;
  logic [W-1:0]  data_b = '0;
  logic [W-1:0]  data_out;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  always #5 clk = ~clk;

  multu_hilo #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .Signal  (sig),
    .dataA   (data_a),
    .dataB   (data_b),
    .dataOut (data_out),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end else begin
      $display("[TB] ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must correspond to a queued commit; the
  // cycle of the pulse shows HI (MFHI), the next cycle shows LO (MFLO).
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("commit_hi", data_out, e[63:32]);
          @(negedge clk);
          check("commit_lo", data_out, e[31:0]);
          check("done_one_cycle", 32'(done), 32'd0);
        end
      end
    end
  end

  task automatic read_check();
    tick(); sig = MFHI;
    @(negedge clk); check("read_hi", data_out, hi_m);
    tick(); sig = MFLO;
    @(negedge clk); check("read_lo", data_out, lo_m);
    tick(); sig = ADD;
    @(negedge clk); check("read_other_zero", data_out, 32'd0);
  endtask

  // One multiply attempt. abort_at / rst_at: edge number (1..32) after which
  // the run is abandoned or reset; 0 = not used. extra: cycles MULTU is held
  // in the finished state before the commit code arrives.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input int abort_at, input int rst_at, input int extra);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    tick(); sig = MULTU; data_a = a; data_b = b;
    for (int k = 1; k <= 32; k++) begin
      tick();
      data_a = $urandom;  // must be ignored once started
      data_b = $urandom;
      if (k == 1) check("busy_after_start", 32'(busy), 32'd1);
      if (k == abort_at) begin
        check("busy_before_abort", 32'(busy), 32'd1);
        sig = ADD;
        tick();
        check("busy_after_abort", 32'(busy), 32'd0);
        return;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        sig = MFHI;
        #1;
        check("rst_hi", data_out, 32'd0);
        sig = MFLO;
        #1;
        check("rst_lo", data_out, 32'd0);
        hi_m = '0;
        lo_m = '0;
        tick();
        sig = ADD;
        rst = 1'b0;
        return;
      end
    end
    check("busy_before_commit", 32'(busy), 32'd1);
    for (int x = 0; x < extra; x++) begin
      tick();
      check("busy_hold", 32'(busy), 32'd1);
    end
    sig = HILO_WR;
    exp_q.push_back(prod);
    hi_m = prod[63:32];
    lo_m = prod[31:0];
    tick(); sig = MFHI;
    check("busy_after_commit", 32'(busy), 32'd0);
    tick(); sig = MFLO;
    tick(); sig = ADD;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int mode;
    // reset state
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out_other", data_out, 32'd0);
    sig = MFHI; #1;
    check("reset_hi", data_out, 32'd0);
    sig = ADD;
    tick(); rst = 1'b0;

    run_mult(32'd3, 32'd5, 10, 0, 0);           // abort after edge 10
    read_check();                                // HI/LO still 0/0
    run_mult(32'd3, 32'd5, 0, 0, 0);            // 0 / 15
    read_check();
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    read_check();
    run_mult(32'd7, 32'd9, 0, 20, 0);           // reset mid-run
    read_check();

    // stray HILO_WR while idle must not write
    run_mult(32'd3, 32'd5, 0, 0, 0);
    tick(); sig = HILO_WR;
    tick(); sig = ADD;
    check("stray_wr_busy", 32'(busy), 32'd0);
    check("stray_wr_done", 32'(done), 32'd0);
    read_check();
    run_mult(32'h0001_0000, 32'h0001_0000, 0, 0, 1);
    read_check();

    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 5);
      if (mode == 0)      run_mult($urandom, $urandom, $urandom_range(1, 32), 0, 0);
      else if (mode == 1) run_mult($urandom, $urandom, 0, $urandom_range(1, 32), 0);
      else                run_mult($urandom, $urandom, 0, 0, $urandom_range(0, 2));
      if (i % 4 == 0) read_check();
    end
    read_check();

    repeat (5) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
